// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an N x N tpumac systolic array pass.
// Ports: clk, rst_n (async low), start, clear_c, abort in;
//   rd_en, rd_addr[AW], mac_en, mac_wren, busy, done out;
//   pass_cnt[16] out when SYSTOLIC_CTRL_PERF_EN is defined.
module systolic_ctrl #(
    parameter int N  = 8,
    parameter int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          clear_c,
    input  logic          abort,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          mac_en,
    output logic          mac_wren,
    output logic          busy,
    output logic          done
`ifdef SYSTOLIC_CTRL_PERF_EN
    ,
    output logic [15:0]   pass_cnt
`endif
);

    localparam int CW = $clog2(2 * N);
    localparam logic [CW-1:0] FEED_LAST  = CW'(N - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          rd_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            rd_d  <= 1'b0;
        end else begin
            state <= state_n;
            // Kill the read-latency term on abort so mac_en drops at once.
            rd_d  <= rd_en & ~abort;
            if (state_n != state)
                cnt <= '0;
            else if (state == S_FEED || state == S_FLUSH)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: begin
                if (start && !abort)
                    state_n = clear_c ? S_CLEAR : S_FEED;
            end
            S_CLEAR: begin
                state_n = abort ? S_IDLE : S_FEED;
            end
            S_FEED: begin
                if (abort)
                    state_n = S_IDLE;
                else if (cnt == FEED_LAST)
                    state_n = S_FLUSH;
            end
            S_FLUSH: begin
                if (abort)
                    state_n = S_IDLE;
                else if (cnt == FLUSH_LAST)
                    state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_en    = (state == S_FEED);
        rd_addr  = rd_en ? AW'(cnt) : '0;
        // CLEAR writes zero into the accumulators via the tied-off Cin.
        mac_en   = (state == S_CLEAR) | (state == S_FLUSH) | rd_d;
        mac_wren = (state == S_CLEAR);
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
    end

`ifdef SYSTOLIC_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pass_cnt <= '0;
        else if (state == S_DONE && pass_cnt != 16'hFFFF)
            pass_cnt <= pass_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: random + directed bench for systolic_ctrl,
// N=4 and N=1 instances against a pass-timeline model.
module tb_systolic_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       clear_c;
    logic       abort;

    logic       rd_en4, mac_en4, mac_wren4, busy4, done4;
    logic [1:0] rd_addr4;
    logic       rd_en1, mac_en1, mac_wren1, busy1, done1;
    logic [0:0] rd_addr1;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [15:0] pass_cnt4, pass_cnt1;
`endif

    int checks;
    int failures;

    int act [2];
    int rel [2];
    int clr [2];
    int pc  [2];

    systolic_ctrl #(.N(4)) dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear_c  (clear_c),
        .abort    (abort),
        .rd_en    (rd_en4),
        .rd_addr  (rd_addr4),
        .mac_en   (mac_en4),
        .mac_wren (mac_wren4),
        .busy     (busy4),
        .done     (done4)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .pass_cnt (pass_cnt4)
`endif
    );

    systolic_ctrl #(.N(1)) dut1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .clear_c  (clear_c),
        .abort    (abort),
        .rd_en    (rd_en1),
        .rd_addr  (rd_addr1),
        .mac_en   (mac_en1),
        .mac_wren (mac_wren1),
        .busy     (busy1),
        .done     (done1)
`ifdef SYSTOLIC_CTRL_PERF_EN
        ,
        .pass_cnt (pass_cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int nof(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Expected outputs from the pass timeline: r is the cycle number
    // since acceptance (1 = first busy cycle), c the clear flag.
    function automatic logic [7:0] expv(input int n, input int a,
                                        input int r, input int c);
        logic bs, dn, re, me, mw;
        int   ad;
        bs = (a != 0);
        dn = bs && (r == 3 * n + c);
        mw = bs && (c != 0) && (r == 1);
        re = bs && (r >= 1 + c) && (r <= n + c);
        ad = re ? (r - 1 - c) : 0;
        me = bs && (((c != 0) && (r == 1)) ||
                    ((r >= 2 + c) && (r <= 3 * n - 1 + c)));
        return {bs, dn, re, me, mw, ad[2:0]};
    endfunction

    function automatic logic [7:0] got4();
        return {busy4, done4, rd_en4, mac_en4, mac_wren4, 1'b0, rd_addr4};
    endfunction

    function automatic logic [7:0] got1();
        return {busy1, done1, rd_en1, mac_en1, mac_wren1, 2'b00, rd_addr1};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                act[i] = 0;
                rel[i] = 0;
                clr[i] = 0;
                pc[i]  = 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (act[i] != 0) begin
                    if (rel[i] == 3 * nof(i) + clr[i]) begin
                        act[i] = 0;
                        if (pc[i] < 65535) pc[i]++;
                    end else if (abort) begin
                        act[i] = 0;
                    end else begin
                        rel[i]++;
                    end
                end else if (start && !abort) begin
                    act[i] = 1;
                    rel[i] = 1;
                    clr[i] = clear_c ? 1 : 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cyc_n4", int'(got4()),
                int'(expv(4, act[0], rel[0], clr[0])));
            chk("cyc_n1", int'(got1()),
                int'(expv(1, act[1], rel[1], clr[1])));
`ifdef SYSTOLIC_CTRL_PERF_EN
            chk("pass_cnt_n4", int'(pass_cnt4), pc[0]);
            chk("pass_cnt_n1", int'(pass_cnt1), pc[1]);
`endif
        end
    end

    // One pass launched at edge 0; tallies event cycles for both sizes.
    task automatic run_pass(input bit c, output int dc4, output int me4,
                            output int rd4, output int wr4,
                            output int dc1, output int me1);
        dc4 = 0; me4 = 0; rd4 = 0; wr4 = 0; dc1 = 0; me1 = 0;
        start   = 1'b1;
        clear_c = c;
        @(posedge clk);
        #1 start = 1'b0;
        clear_c = 1'b0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (done4) dc4 = cyc;
            if (mac_en4) me4++;
            if (rd_en4) rd4++;
            if (mac_wren4) wr4++;
            if (done1) dc1 = cyc;
            if (mac_en1) me1++;
        end
    endtask

    int dc4, me4, rd4, wr4, dc1, me1, ndone;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        clear_c  = 1'b0;
        abort    = 1'b0;
        #12;
        chk("reset_out_n4", int'(got4()), 0);
        chk("reset_out_n1", int'(got1()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_pass(1'b0, dc4, me4, rd4, wr4, dc1, me1);
        chk("n4_done_cycle", dc4, 12);
        chk("n4_mac_en_cycles", me4, 10);
        chk("n4_rd_en_cycles", rd4, 4);
        chk("n4_wren_cycles", wr4, 0);
        chk("n1_done_cycle", dc1, 3);
        chk("n1_mac_en_cycles", me1, 1);

        run_pass(1'b1, dc4, me4, rd4, wr4, dc1, me1);
        chk("n4c_done_cycle", dc4, 13);
        chk("n4c_mac_en_cycles", me4, 11);
        chk("n4c_wren_cycles", wr4, 1);
        chk("n1c_done_cycle", dc1, 4);

        // Abort on the third FLUSH cycle (cycle 7), restart right after.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy4), 0);
        chk("abort_mac_en", int'(mac_en4), 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", int'(busy4), 1);
        for (int cyc = 0; cyc < 16; cyc++) @(negedge clk);

        // Starts during FEED and DONE must be ignored.
        ndone = 0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            start = (cyc == 2 || cyc == 12);
            if (done4) ndone++;
        end
        start = 1'b0;
        chk("one_done_per_start", ndone, 1);

        // Start together with abort in IDLE.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", int'(busy4), 0);

        // Async reset in the middle of FEED.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_n4", int'(got4()), 0);
        chk("midreset_n1", int'(got1()), 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        run_pass(1'b0, dc4, me4, rd4, wr4, dc1, me1);
        chk("post_reset_done", dc4, 12);

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rand_reset_n4", int'(got4()), 0);
                #1 rst_n = 1'b1;
            end
            start   = ($urandom_range(0, 3) == 0);
            clear_c = $urandom_range(0, 1) == 1;
            abort   = ($urandom_range(0, 19) == 0);
        end
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 8: systolic array dimension (N x N tpumac grid, N >= 1).
REQ-002 The block SHALL have parameter AW, default $clog2(N) (minimum 1): operand buffer address width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one matrix-multiply pass, sampled in IDLE only.
REQ-006 The block SHALL have port clear_c, input, 1 bit: sampled with start; 1 zeroes the accumulators before feeding.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of the current pass.
REQ-008 The block SHALL have port rd_en, output, 1 bit: read strobe to the A and B operand buffers.
REQ-009 The block SHALL have port rd_addr, output, AW bits: operand index k, shared by the A and B buffers.
REQ-010 The block SHALL have port mac_en, output, 1 bit: broadcast to every tpumac en.
REQ-011 The block SHALL have port mac_wren, output, 1 bit: broadcast to every tpumac WrEn; the array Cin is tied to zero.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at pass completion.

Function
REQ-014 The block SHALL implement the states IDLE, CLEAR, FEED, FLUSH and DONE.
REQ-015 IDLE SHALL move to CLEAR when start=1 and clear_c=1, and to FEED when start=1 and clear_c=0.
REQ-016 CLEAR SHALL last 1 cycle with mac_en=1 and mac_wren=1, and SHALL then move to FEED.
REQ-017 FEED SHALL last N cycles with rd_en=1 and rd_addr=0,1,...,N-1 on consecutive cycles, and SHALL then move to FLUSH.
REQ-018 FLUSH SHALL last 2N-1 cycles with rd_en=0 and rd_addr=0, and SHALL then move to DONE.
REQ-019 DONE SHALL last 1 cycle with done=1, and SHALL then move to IDLE.
REQ-020 mac_en SHALL equal rd_en delayed by one cycle OR the FLUSH state, which covers the 1-cycle buffer read latency and gives exactly 3N-2 consecutive mac_en cycles per pass.
REQ-021 mac_wren SHALL be 0 in every state except CLEAR.
REQ-022 start SHALL be ignored while busy=1, with no queuing.
REQ-023 In IDLE, start and abort asserted together SHALL have abort win: no pass starts.
REQ-024 abort=1 in CLEAR, FEED or FLUSH SHALL force IDLE on the next edge, with done never pulsed.
REQ-025 After an abort, rd_en, mac_en and mac_wren SHALL be 0 from the next cycle, including the delayed mac_en term.
REQ-026 abort=1 in DONE SHALL have no effect: done still pulses.
REQ-027 The phase counter SHALL be ceil(log2(2N)) bits wide, SHALL reload at every state entry, and SHALL never wrap within a state.
REQ-028 With N=1, FEED SHALL last 1 cycle and FLUSH 1 cycle, giving exactly 1 mac_en cycle.
REQ-029 The first FEED cycle SHALL be the cycle after start is sampled (plus 1 cycle if CLEAR is taken).

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE and the phase counter and read-latency register to 0, independent of clk.
REQ-031 Under reset, rd_en, rd_addr, mac_en, mac_wren, busy and done SHALL all be 0.
REQ-032 Reset asserted mid-pass SHALL discard the pass with no done pulse.
REQ-033 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-034 When macro SYSTOLIC_CTRL_PERF_EN is defined, the block SHALL add output pass_cnt, 16 bits.
REQ-035 pass_cnt SHALL increment on each done pulse, saturate at 16'hFFFF, and count neither aborted passes nor passes cut by reset.
REQ-036 pass_cnt SHALL be reset to 0 by rst_n.
REQ-037 When SYSTOLIC_CTRL_PERF_EN is undefined, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-038 N=4, start=1, clear_c=0 at edge 0 -> rd_en on cycles 1-4 with rd_addr 0,1,2,3; mac_en on cycles 2-11 (10 cycles); done on cycle 12; busy on cycles 1-12.
REQ-039 N=4, start=1, clear_c=1 -> mac_wren=1 and mac_en=1 on cycle 1 only; every other event shifted +1 (done on cycle 13).
REQ-040 N=4, abort on the 3rd FLUSH cycle -> IDLE next cycle; mac_en=0 next cycle; no done; a new start is accepted 1 cycle later.
REQ-041 start pulsed during FEED and during DONE -> ignored; exactly one done per accepted start.
REQ-042 rst_n low mid-FEED, between clock edges -> all outputs 0 immediately; after release, a fresh pass completes normally.
REQ-043 N=1, start=1 -> 1 rd_en cycle, 1 mac_en cycle, done on cycle 3; with SYSTOLIC_CTRL_PERF_EN, 3 passes -> pass_cnt=3, and pass_cnt is unchanged after an aborted pass.
